delay_scheduler: RTL



---
 rtl/delay_scheduler_pkg.sv | 21 ++
 rtl/delay_scheduler_counter.sv | 33 +++
 rtl/delay_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/delay_scheduler_pkg.sv
// Shared constants for the alarm delay scheduler: requester indices, FSM
// encoding and default delay lengths at the 10 kHz LSOSC rate.
package delay_scheduler_pkg;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned IDX_ENTRY = 0;
  localparam int unsigned IDX_EXIT  = 1;
  localparam int unsigned IDX_SIREN = 2;

  localparam int unsigned DEF_CNT_W       = 18;
  localparam int unsigned DEF_ENTRY_TICKS = 150000;  // 15 s
  localparam int unsigned DEF_EXIT_TICKS  = 200000;  // 20 s
  localparam int unsigned DEF_SIREN_TICKS = 250000;  // 25 s

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIN   = 2'd2
  } state_e;

endpackage

// File: rtl/delay_scheduler_counter.sv
// Loadable down-counter shared by all delays; never wraps below zero.
module delay_counter #(
  parameter int unsigned CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             is_one_c
);

  logic [CNT_W-1:0] cnt_q;

  // Clear beats load beats decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign value    = cnt_q;
  assign is_one_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/delay_scheduler.sv
// Arbitrates entry/exit/siren delay requests onto one shared down-counter
// and pulses the owner's DONE when its delay expires.
import delay_scheduler_pkg::*;

module delay_scheduler #(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned ENTRY_TICKS = DEF_ENTRY_TICKS,
  parameter int unsigned EXIT_TICKS  = DEF_EXIT_TICKS,
  parameter int unsigned SIREN_TICKS = DEF_SIREN_TICKS
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] CANCEL,
  output logic [NUM_REQ-1:0] GNT,
  output logic [NUM_REQ-1:0] DONE,
  output logic               BUSY,
  output logic [CNT_W-1:0]   REMAIN
);

  if (ENTRY_TICKS == 0 || EXIT_TICKS == 0 || SIREN_TICKS == 0) begin : g_zero_ticks
    $error("delay_scheduler: TICKS parameters must be non-zero");
  end
  if (CNT_W == 0 || ((ENTRY_TICKS | EXIT_TICKS | SIREN_TICKS) >> CNT_W) != 0) begin : g_ticks_fit
    $error("delay_scheduler: TICKS parameters must fit in CNT_W bits");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] pick;

  logic               cnt_load, cnt_dec, cnt_clr, cnt_is_one_c;
  logic [CNT_W-1:0]   cnt_load_val, cnt_value;

  function automatic logic [NUM_REQ-1:0] pick_lowest(input logic [NUM_REQ-1:0] v);
    return v & (~v + NUM_REQ'(1));
  endfunction

  function automatic logic [CNT_W-1:0] ticks_of(input logic [NUM_REQ-1:0] oh);
    if (oh[IDX_ENTRY])     return CNT_W'(ENTRY_TICKS);
    else if (oh[IDX_EXIT]) return CNT_W'(EXIT_TICKS);
    else                   return CNT_W'(SIREN_TICKS);
  endfunction

  delay_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .value    (cnt_value),
    .is_one_c (cnt_is_one_c)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pend_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // A REQ from the current owner is a retrigger, never a new pending entry.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    pend_d       = (pend_q | (REQ & ~gnt_q)) & ~CANCEL;
    pick         = '0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    cnt_clr      = 1'b0;

    case (state_q)
      IDLE: begin
        pick = pick_lowest(pend_d);
        if (pick != '0) begin
          gnt_d        = pick;
          pend_d       = pend_d & ~pick;
          cnt_load     = 1'b1;
          cnt_load_val = ticks_of(pick);
          state_d      = COUNT;
        end
      end
      COUNT: begin
        if ((CANCEL & gnt_q) != '0) begin
          gnt_d   = '0;
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if ((REQ & gnt_q) != '0) begin
          cnt_load     = 1'b1;
          cnt_load_val = ticks_of(gnt_q);
        end else if (cnt_is_one_c) begin
          cnt_dec = 1'b1;
          gnt_d   = '0;
          done_d  = gnt_q;
          state_d = FIN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign GNT    = gnt_q;
  assign DONE   = done_q;
  assign BUSY   = busy_q;
  assign REMAIN = cnt_value;

endmodule
